// File: rtl/xc_malu_divp_if.sv
// Request/response bundle for the xc_malu_divp radix-2 divider.
interface xc_malu_divp_if #(
    parameter int unsigned XLEN = 32
);
    logic            flush;
    logic            valid;
    logic            uop_div;
    logic            uop_divu;
    logic            uop_rem;
    logic            uop_remu;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] result;
    logic            ready;

    modport master (
        output flush, valid, uop_div, uop_divu, uop_rem, uop_remu, rs1, rs2,
        input  result, ready
    );

    modport slave (
        input  flush, valid, uop_div, uop_divu, uop_rem, uop_remu, rs1, rs2,
        output result, ready
    );
endinterface

// File: rtl/xc_malu_divp.sv
// Multi-cycle radix-2 restoring divider for div/divu/rem/remu (one quotient bit per cycle).
// Optional zero/small-operand early-out is enabled by defining XC_MALU_DIVP_EARLY_EN.
module xc_malu_divp #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned CW   = $clog2(XLEN)
) (
    input logic           clock,
    input logic           resetn,
    xc_malu_divp_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q, quo_q, div_q, result_q;
    logic            negq_q, negr_q, is_rem_q, ready_q;
    logic            accept, step, finish;

    // Operand decode: signed uops work on magnitudes
    logic            op_signed, op_rem, rs2_zero;
    logic [XLEN-1:0] abs1, abs2;

    assign op_signed = bus.uop_div | bus.uop_rem;
    assign op_rem    = (bus.uop_rem | bus.uop_remu) & ~(bus.uop_div | bus.uop_divu);
    assign rs2_zero  = (bus.rs2 == '0);
    assign abs1      = (op_signed && bus.rs1[XLEN-1]) ? -bus.rs1 : bus.rs1;
    assign abs2      = (op_signed && bus.rs2[XLEN-1]) ? -bus.rs2 : bus.rs2;

    // One restoring step: the sign of the XLEN+1-bit trial difference decides the quotient bit
    logic [XLEN:0]   shifted, trial;
    logic            ge;
    logic [XLEN-1:0] rem_n, quo_n, q_fin, r_fin, res_fin;

    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign trial   = shifted - {1'b0, div_q};
    assign ge      = ~trial[XLEN];
    assign rem_n   = ge ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_n   = {quo_q[XLEN-2:0], ge};
    assign q_fin   = negq_q ? -quo_n : quo_n;
    assign r_fin   = negr_q ? -rem_n : rem_n;
    assign res_fin = is_rem_q ? r_fin : q_fin;

`ifdef XC_MALU_DIVP_EARLY_EN
    // Results that need no iteration: x/0, 0/y and |x|<|y|
    logic            early, early_hit;
    logic [XLEN-1:0] early_res;

    assign early_hit = rs2_zero || (bus.rs1 == '0) || (abs1 < abs2);
    assign early_res = op_rem ? bus.rs1 : (rs2_zero ? '1 : '0);
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
`ifdef XC_MALU_DIVP_EARLY_EN
        early   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.valid && !bus.flush) begin
                    accept  = 1'b1;
                    state_d = CALC;
`ifdef XC_MALU_DIVP_EARLY_EN
                    if (early_hit) begin
                        early   = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                if (bus.flush || !bus.valid) begin
                    state_d = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_q == CW'(XLEN - 1)) begin
                        finish  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.flush || !bus.valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and operation context
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            is_rem_q <= 1'b0;
        end else if (accept) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= abs1;
            div_q    <= abs2;
            negq_q   <= op_signed && (bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1]) && !rs2_zero;
            negr_q   <= op_signed && bus.rs1[XLEN-1];
            is_rem_q <= op_rem;
        end else if (step) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            if (!finish) cnt_q <= cnt_q + CW'(1);
        end
    end

    // Registered outputs; result is forced to zero whenever ready is low
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            ready_q <= (state_d == DONE);
            if (finish) begin
                result_q <= res_fin;
`ifdef XC_MALU_DIVP_EARLY_EN
            end else if (early) begin
                result_q <= early_res;
`endif
            end else if (state_d != DONE) begin
                result_q <= '0;
            end
        end
    end

    assign bus.ready  = ready_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_xc_malu_divp.sv
// Scoreboard bench for xc_malu_divp: directed 32-bit cases plus randomized 64-bit traffic.
// Latency expectations follow XC_MALU_DIVP_EARLY_EN when it is defined.
module tb_xc_malu_divp;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    xc_malu_divp_if #(.XLEN(32)) b32 ();
    xc_malu_divp_if #(.XLEN(64)) b64 ();

    xc_malu_divp #(.XLEN(32)) u32 (.clock(clock), .resetn(resetn), .bus(b32));
    xc_malu_divp #(.XLEN(64)) u64 (.clock(clock), .resetn(resetn), .bus(b64));

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [63:0] q32[$];
    logic [63:0] q64[$];
    logic        pr32 = 1'b0;
    logic        pr64 = 1'b0;

    localparam int ND = 14;
    // ops: 0 div, 1 divu, 2 rem, 3 remu
    int          d_op [ND] = '{1, 3, 0, 2, 0, 0, 2, 0, 2, 3, 1, 1, 0, 2};
    logic [63:0] d_a  [ND] = '{64'd100, 64'd100, 64'hFFFFFFF9, 64'hFFFFFFF9, 64'd7, 64'd5, 64'd5,
                              64'h80000000, 64'h80000000, 64'd123, 64'd123, 64'd0, 64'd3, 64'hFFFFFFFD};
    logic [63:0] d_b  [ND] = '{64'd7, 64'd7, 64'd2, 64'd2, 64'hFFFFFFFE, 64'd0, 64'd0,
                              64'hFFFFFFFF, 64'hFFFFFFFF, 64'd0, 64'd0, 64'd5, 64'hFFFFFFF0, 64'd10};
    logic [63:0] d_e  [ND] = '{64'd14, 64'd2, 64'hFFFFFFFD, 64'hFFFFFFFF, 64'hFFFFFFFD, 64'hFFFFFFFF, 64'd5,
                              64'h80000000, 64'd0, 64'd123, 64'hFFFFFFFF, 64'd0, 64'd0, 64'hFFFFFFFD};

    function automatic logic [63:0] ref32(input int op, input logic [63:0] a64, input logic [63:0] b64);
        logic [31:0] a, b, r;
        int sa, sb;
        a = a64[31:0]; b = b64[31:0];
        sa = signed'(a); sb = signed'(b);
        r = '0;
        case (op)
            0: r = (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(sa / sb);
            1: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            2: r = (b == 0) ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return {32'd0, r};
    endfunction

    function automatic logic [63:0] ref64(input int op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mn, r;
        longint sa, sb;
        mn = 64'h8000000000000000;
        sa = signed'(a); sb = signed'(b);
        r = '0;
        case (op)
            0: r = (b == 0) ? '1 : (a == mn && b == '1) ? mn : 64'(sa / sb);
            1: r = (b == 0) ? '1 : a / b;
            2: r = (b == 0) ? a : (a == mn && b == '1) ? 64'd0 : 64'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input int w, input int op, input logic [63:0] a, input logic [63:0] b);
`ifdef XC_MALU_DIVP_EARLY_EN
        logic [63:0] mask, ma, mb;
        logic sg;
`endif
        int lat;
        lat = w + 1;
`ifdef XC_MALU_DIVP_EARLY_EN
        mask = (w == 32) ? 64'hFFFFFFFF : '1;
        sg = (op == 0) || (op == 2);
        ma = a & mask; mb = b & mask;
        if (sg && ma[w-1]) ma = (-ma) & mask;
        if (sg && mb[w-1]) mb = (-mb) & mask;
        if (mb == 0 || ma == 0 || ma < mb) lat = 1;
`endif
        return lat;
    endfunction

    task automatic drive(input int w, input logic v, input logic f, input int op,
                         input logic [63:0] a, input logic [63:0] b);
        if (w == 32) begin
            b32.valid = v; b32.flush = f;
            b32.uop_div = (op == 0); b32.uop_divu = (op == 1);
            b32.uop_rem = (op == 2); b32.uop_remu = (op == 3);
            b32.rs1 = a[31:0]; b32.rs2 = b[31:0];
        end else begin
            b64.valid = v; b64.flush = f;
            b64.uop_div = (op == 0); b64.uop_divu = (op == 1);
            b64.uop_rem = (op == 2); b64.uop_remu = (op == 3);
            b64.rs1 = a; b64.rs2 = b;
        end
    endtask

    function automatic logic get_ready(input int w);
        return (w == 32) ? b32.ready : b64.ready;
    endfunction

    function automatic logic [63:0] get_result(input int w);
        return (w == 32) ? {32'd0, b32.result} : b64.result;
    endfunction

    // Issue one operation to completion; optionally reset the DUT while it holds DONE
    task automatic run(input int w, input int op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] expv, input bit rst_done);
        int cyc, lat;
        logic seen;
        lat = exp_lat(w, op, a, b);
        if (w == 32) q32.push_back(expv); else q64.push_back(expv);
        drive(w, 1'b1, 1'b0, op, a, b);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc <= w + 10) begin
            @(negedge clock);
            if (get_ready(w)) seen = 1'b1;
            else begin cyc++; @(posedge clock); #1; end
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL latency_w%0d: ready never rose (op=%0d a=%h b=%h), required cycle %0d", w, op, a, b, lat);
            if (w == 32) void'(q32.pop_back()); else void'(q64.pop_back());
        end else if (cyc != lat) begin
            n_fail++;
            $display("FAIL latency_w%0d: ready in cycle %0d, required %0d (op=%0d a=%h b=%h)", w, cyc, lat, op, a, b);
        end
        @(posedge clock); #1;
        if (seen) begin
            n_chk++;
            if (get_ready(w) !== 1'b1 || get_result(w) !== expv) begin
                n_fail++;
                $display("FAIL done_hold_w%0d: ready=%b result=%h, required ready=1 result=%h", w, get_ready(w), get_result(w), expv);
            end
        end
        if (rst_done) begin
            #2 resetn = 1'b0;
            #1;
            n_chk++;
            if (get_ready(w) !== 1'b0 || get_result(w) !== 64'd0) begin
                n_fail++;
                $display("FAIL reset_in_done_w%0d: ready=%b result=%h, required 0/0", w, get_ready(w), get_result(w));
            end
            drive(w, 1'b0, 1'b0, 0, 64'd0, 64'd0);
            @(negedge clock); #2 resetn = 1'b1;
            @(posedge clock); #1;
        end else begin
            drive(w, 1'b0, 1'b0, op, a, b);
            @(posedge clock); #1;
        end
    endtask

    // Start an operation and kill it (flush or valid drop) k cycles later
    task automatic abort(input int w, input int op, input logic [63:0] a, input logic [63:0] b,
                         input int k, input bit use_flush);
        drive(w, 1'b1, 1'b0, op, a, b);
        repeat (k) begin @(posedge clock); #1; end
        if (use_flush) drive(w, 1'($urandom_range(0, 1)), 1'b1, op, a, b);
        else           drive(w, 1'b0, 1'b0, op, a, b);
        @(posedge clock); #1;
        drive(w, 1'b0, 1'b0, op, a, b);
        n_chk++;
        if (get_ready(w) !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle_w%0d: ready=%b after abort at cycle %0d, required 0", w, get_ready(w), k);
        end
    endtask

    // Monitor: each rising ready consumes one scoreboard entry; idle result must read zero
    always @(negedge clock) begin
        logic [63:0] e;
        if (b32.ready && !pr32) begin
            n_chk++;
            if (q32.size() == 0) begin
                n_fail++;
                $display("FAIL result32: unexpected ready, result=%h, required no response", b32.result);
            end else begin
                e = q32.pop_front();
                if (b32.result !== e[31:0]) begin
                    n_fail++;
                    $display("FAIL result32: got %h, required %h", b32.result, e[31:0]);
                end
            end
        end
        if (!b32.ready) begin
            n_chk++;
            if (b32.result !== 32'd0) begin
                n_fail++;
                $display("FAIL idle_zero32: result=%h while ready=0, required 0", b32.result);
            end
        end
        if (b64.ready && !pr64) begin
            n_chk++;
            if (q64.size() == 0) begin
                n_fail++;
                $display("FAIL result64: unexpected ready, result=%h, required no response", b64.result);
            end else begin
                e = q64.pop_front();
                if (b64.result !== e) begin
                    n_fail++;
                    $display("FAIL result64: got %h, required %h", b64.result, e);
                end
            end
        end
        if (!b64.ready) begin
            n_chk++;
            if (b64.result !== 64'd0) begin
                n_fail++;
                $display("FAIL idle_zero64: result=%h while ready=0, required 0", b64.result);
            end
        end
        pr32 = b32.ready;
        pr64 = b64.ready;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, b;
        int op, kind, mode, lat;
        drive(32, 1'b0, 1'b0, 0, 64'd0, 64'd0);
        drive(64, 1'b0, 1'b0, 0, 64'd0, 64'd0);
        repeat (3) @(posedge clock);
        #1;
        n_chk++;
        if (b32.ready !== 1'b0 || b32.result !== 32'd0 || b64.ready !== 1'b0 || b64.result !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_state: ready32=%b result32=%h ready64=%b result64=%h, required all 0",
                     b32.ready, b32.result, b64.ready, b64.result);
        end
        resetn = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < ND; i++) run(32, d_op[i], d_a[i], d_b[i], d_e[i], 1'b0);

        // Flush in cycle 10 of divu 1000/3, new divu 9/3 presented in cycle 11
        drive(32, 1'b1, 1'b0, 1, 64'd1000, 64'd3);
        repeat (10) begin @(posedge clock); #1; end
        drive(32, 1'b1, 1'b1, 1, 64'd1000, 64'd3);
        @(posedge clock); #1;
        n_chk++;
        if (b32.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cycle11: ready=%b, required 0", b32.ready);
        end
        run(32, 1, 64'd9, 64'd3, 64'd3, 1'b0);

        // Reset pulse in the middle of CALC, then a clean operation
        drive(32, 1'b1, 1'b0, 1, 64'd1000, 64'd3);
        repeat (5) begin @(posedge clock); #1; end
        #2 resetn = 1'b0;
        #1;
        n_chk++;
        if (b32.ready !== 1'b0 || b32.result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_calc: ready=%b result=%h, required 0/0", b32.ready, b32.result);
        end
        drive(32, 1'b0, 1'b0, 1, 64'd1000, 64'd3);
        @(negedge clock); #2 resetn = 1'b1;
        @(posedge clock); #1;
        run(32, 1, 64'd100, 64'd7, 64'd14, 1'b0);
        run(32, 3, 64'd1000, 64'd3, 64'd1, 1'b1);
        run(32, 0, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 1'b0);

        for (int i = 0; i < 600; i++) begin
            op   = int'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 9));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case (kind)
                0: b = 64'd0;
                1: begin a = 64'h8000000000000000; b = '1; end
                2: a = 64'($urandom_range(0, 50));
                3: b = 64'($urandom_range(1, 50));
                4: begin a = -64'($urandom_range(0, 50)); b = 64'($urandom_range(1, 9)); end
                5: b = b >> $urandom_range(1, 63);
                default: ;
            endcase
            lat  = exp_lat(64, op, a, b);
            mode = int'($urandom_range(0, 9));
            if (mode == 0 && lat > 1)      abort(64, op, a, b, int'($urandom_range(0, lat - 1)), 1'b1);
            else if (mode == 1 && lat > 1) abort(64, op, a, b, int'($urandom_range(1, lat - 1)), 1'b0);
            else                           run(64, op, a, b, ref64(op, a, b), 1'b0);
        end

        repeat (4) @(posedge clock);
        #1;
        n_chk++;
        if (q32.size() != 0 || q64.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0/0", q32.size(), q64.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
